// File: rtl/countdown_pkg.sv
// Shared definitions for countdown_timer: FSM state encoding and WIDTH limits.
package countdown_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable, pausable down-counter with registered expiry flags.
// Define COUNTDOWN_RELOAD_EN for periodic mode (reload from preset on expiry).
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             tick,
  output logic [WIDTH-1:0] out,
  output logic             running,
  output logic             zero,
  output logic             timeout
);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] next_out;
  logic             next_timeout;
`ifdef COUNTDOWN_RELOAD_EN
  logic [WIDTH-1:0] preset;
  logic [WIDTH-1:0] next_preset;
`endif

  // State and all outputs are registered; flags derive from the next values.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state   <= EXPIRED;
      out     <= '0;
      running <= 1'b0;
      zero    <= 1'b1;
      timeout <= 1'b0;
`ifdef COUNTDOWN_RELOAD_EN
      preset  <= '0;
`endif
    end else begin
      state   <= next_state;
      out     <= next_out;
      running <= (next_state == RUN);
      zero    <= (next_out == '0);
      timeout <= next_timeout;
`ifdef COUNTDOWN_RELOAD_EN
      preset  <= next_preset;
`endif
    end
  end

  // Next-state and datapath; priority load > pause > start > tick.
  always_comb begin
    next_state   = state;
    next_out     = out;
    next_timeout = 1'b0;
`ifdef COUNTDOWN_RELOAD_EN
    next_preset  = preset;
`endif
    if (load) begin
      next_state = IDLE;
      next_out   = load_val;
`ifdef COUNTDOWN_RELOAD_EN
      next_preset = load_val;
`endif
    end else begin
      case (state)
        RUN: begin
          if (pause) begin
            next_state = PAUSE;
          end else if (tick) begin
            if (out == WIDTH'(1)) begin
              next_timeout = 1'b1;
`ifdef COUNTDOWN_RELOAD_EN
              next_out     = preset;
`else
              next_out     = '0;
              next_state   = EXPIRED;
`endif
            end else if (out > WIDTH'(1)) begin
              next_out = out - WIDTH'(1);
            end
          end
        end
        IDLE, PAUSE: begin
          // A zero count refuses to run and expires silently.
          if (start) begin
            next_state = (out != '0) ? RUN : EXPIRED;
          end
        end
        default: begin
          next_out = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (default WIDTH = 4).
module tb_countdown_timer;

  localparam int unsigned W = 4;

  logic         clock = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         tick = 1'b0;
  logic [W-1:0] out;
  logic         running;
  logic         zero;
  logic         timeout;

  int errors = 0;
  int checks = 0;

  countdown_timer #(.WIDTH(W)) dut (
    .clock(clock), .clr(clr), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .tick(tick),
    .out(out), .running(running), .zero(zero), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, sample 1 time unit after the edge, then idle inputs.
  task automatic cyc(input logic l, input logic [W-1:0] lv, input logic s,
                     input logic p, input logic t);
    load = l; load_val = lv; start = s; pause = p; tick = t;
    @(posedge clock);
    #1;
    load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
  endtask

  task automatic flags(input string tag, input logic [W-1:0] o, input logic r,
                       input logic z, input logic t);
    check({tag, ".out"}, 32'(out), 32'(o));
    check({tag, ".running"}, 32'(running), 32'(r));
    check({tag, ".zero"}, 32'(zero), 32'(z));
    check({tag, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    // Power-on reset
    #3 clr = 1'b1;
    #1 flags("rst", 4'd0, 1'b0, 1'b1, 1'b0);
    @(posedge clock); #1;
    clr = 1'b0;
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    flags("rst_start_ignored", 4'd0, 1'b0, 1'b1, 1'b0);

    // Basic one-shot count from 3
    cyc(1'b1, 4'd3, 1'b0, 1'b0, 1'b0); flags("b_load", 4'd3, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);   flags("b_start", 4'd3, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);   flags("b_t1", 4'd2, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);   flags("b_t2", 4'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);   flags("b_t3", 4'd0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);   flags("b_after", 4'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);   flags("b_exp_start", 4'd0, 1'b0, 1'b1, 1'b0);

    // Asynchronous clear mid-run at out = 5
    cyc(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);   flags("c_run", 4'd5, 1'b1, 1'b0, 1'b0);
    tick = 1'b1;
    #2 clr = 1'b1;
    #1 flags("c_async", 4'd0, 1'b0, 1'b1, 1'b0);
    tick = 1'b0;
    @(posedge clock); #1;
    clr = 1'b0;
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);   flags("c_release", 4'd0, 1'b0, 1'b1, 1'b0);

    // Pause with a simultaneous tick, then resume
    cyc(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);   flags("p_two", 4'd7, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);   flags("p_pause", 4'd7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    flags("p_hold", 4'd7, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);   flags("p_resume", 4'd7, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);   flags("p_tick", 4'd6, 1'b1, 1'b0, 1'b0);

    // Priority: load beats pause and tick
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);   flags("pr_four", 4'd4, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 4'd12, 1'b0, 1'b1, 1'b1); flags("pr_load", 4'd12, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);   flags("pr_idle_tick", 4'd12, 1'b0, 1'b0, 1'b0);

    // Zero preset refuses to run
    cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b0); flags("z_load", 4'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);   flags("z_start", 4'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);   flags("z_tick", 4'd0, 1'b0, 1'b1, 1'b0);

    // Expiry from 2: periodic reload or one-shot
    cyc(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);   flags("r_start", 4'd2, 1'b1, 1'b0, 1'b0);
`ifdef COUNTDOWN_RELOAD_EN
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
      if (i % 2 == 0) flags("r_down", 4'd1, 1'b1, 1'b0, 1'b0);
      else            flags("r_reload", 4'd2, 1'b1, 1'b0, 1'b1);
    end
`else
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);   flags("r_t1", 4'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);   flags("r_t2", 4'd0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);   flags("r_t3", 4'd0, 1'b0, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
